// File: rtl/regfile_clr.sv
// Byte-maskable register file with two combinational read ports, one write port,
// write-to-read bypass, and a hardware clear sequencer that zeroes every entry.
module regfile_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                clearReq,
  input  logic                regWrite,
  input  logic [DATA_W/8-1:0] writeMask,
  input  logic [ADDR_W-1:0]   regDest,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [ADDR_W-1:0]   readReg1,
  input  logic [ADDR_W-1:0]   readReg2,
  output logic [DATA_W-1:0]   readData1,
  output logic [DATA_W-1:0]   readData2,
  output logic                ready,
  output logic                clearing
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                run;
  logic                wr_fire;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Read mux: CLEAR forces zero; an in-flight write to the same entry is merged in.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              run_i,
    input logic              fire_i,
    input logic [ADDR_W-1:0] dest_i,
    input logic [DATA_W-1:0] wdata_i,
    input logic [NB-1:0]     wmask_i,
    input logic [DATA_W-1:0] stored_i
  );
    logic [DATA_W-1:0] res;
    res = stored_i;
    if (!run_i || is_zero_reg(addr)) begin
      res = '0;
    end else if (fire_i && (dest_i == addr)) begin
      res = byte_merge(stored_i, wdata_i, wmask_i);
    end
    return res;
  endfunction

  always_comb begin
    run       = (state_q == ST_RUN);
    wr_fire   = run && regWrite && !clearReq;
    state_d   = state_q;
    clr_addr_d = clr_addr_q;
    mem_we    = 1'b0;
    mem_waddr = regDest;
    mem_wdata = byte_merge(mem_q[regDest], writeData, writeMask);

    if (state_q == ST_CLEAR) begin
      mem_we     = 1'b1;
      mem_waddr  = clr_addr_q;
      mem_wdata  = '0;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
    end else if (clearReq) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
    end else if (wr_fire && !is_zero_reg(regDest)) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    readData1 = read_port(readReg1, run, wr_fire, regDest, writeData, writeMask, mem_q[readReg1]);
    readData2 = read_port(readReg2, run, wr_fire, regDest, writeData, writeMask, mem_q[readReg2]);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Storage carries no reset; the clear sequencer is what zeroes it.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready    = (state_q == ST_RUN);
  assign clearing = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_clr.sv
// Self-checking bench for regfile_clr: table-driven read/write vectors, a scoreboard
// queue of expected read pairs, and hand-written clear/reset sequences.
module tb_regfile_clr;

  logic        clock;
  logic        reset_;
  logic        clearReq;
  logic        regWrite;
  logic [3:0]  writeMask;
  logic [4:0]  regDest;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        ready;
  logic        clearing;

  regfile_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clock(clock), .reset_(reset_), .clearReq(clearReq), .regWrite(regWrite),
    .writeMask(writeMask), .regDest(regDest), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1),
    .readData2(readData2), .ready(ready), .clearing(clearing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[12];
  logic [31:0] mdl[32];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  task automatic mdl_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    if (a != 5'd0) begin
      for (int b = 0; b < 4; b++) if (m[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Present a read pair, queue the model's answer, then compare what the DUT shows.
  task automatic sb_read(input string name, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge clock);
    readReg1 = a1;
    readReg2 = a2;
    sbq.push_back('{e1: mdl_read(a1), e2: mdl_read(a2)});
    #2;
    e = sbq.pop_front();
    check($sformatf("%s_r1[%0d]", name, a1), readData1, e.e1);
    check($sformatf("%s_r2[%0d]", name, a2), readData2, e.e2);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    regWrite  = 1'b1;
    regDest   = a;
    writeData = d;
    writeMask = m;
    @(posedge clock);
    mdl_write(a, d, m);
    #1;
    regWrite = 1'b0;
  endtask

  // Counts rising edges until ready is seen high; bounded so a stuck DUT still ends.
  task automatic wait_ready(input string name, input int exp_edges);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 100) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    check(name, cnt, exp_edges);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset_    = 1'b0;
    clearReq  = 1'b0;
    regWrite  = 1'b1;
    regDest   = 5'd3;
    writeData = 32'hFFFF_FFFF;
    writeMask = 4'hF;
    readReg1  = 5'd3;
    readReg2  = 5'd7;
    for (int i = 0; i < 32; i++) mdl[i] = 32'hX;

    // Reset and clear with a write held active throughout
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_clearing", {31'b0, clearing}, 32'd1);
    check("rst_rd1", readData1, 32'h0);
    check("rst_rd2", readData2, 32'h0);
    @(negedge clock);
    reset_ = 1'b1;
    wait_ready("reset_clear_edges", 32);
    check("run_clearing", {31'b0, clearing}, 32'd0);
    regWrite = 1'b0;
    clear_model();
    for (int k = 0; k < 32; k += 2) sb_read("post_reset", 5'(k), 5'(k + 1));

    // Write/read sweep
    for (int k = 0; k < 32; k++) do_write(5'(k), 32'(k + 1), 4'hF);
    for (int k = 0; k < 32; k++) sb_read("sweep", 5'(k), 5'(k + 1));

    // Table-driven vectors: reads checked combinationally before the edge
    vecs[0]  = '{1'b0, 4'hF, 5'd0,  32'h0,         5'd5,  5'd6,  32'h0000_0006, 32'h0000_0007};
    vecs[1]  = '{1'b1, 4'hF, 5'd5,  32'h1234_5678, 5'd1,  5'd2,  32'h0000_0002, 32'h0000_0003};
    vecs[2]  = '{1'b1, 4'h5, 5'd5,  32'hAABB_CCDD, 5'd5,  5'd5,  32'h12BB_56DD, 32'h12BB_56DD};
    vecs[3]  = '{1'b0, 4'h0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h12BB_56DD, 32'h0000_0000};
    vecs[4]  = '{1'b1, 4'hF, 5'd7,  32'h1111_1111, 5'd7,  5'd8,  32'h1111_1111, 32'h0000_0009};
    vecs[5]  = '{1'b1, 4'h3, 5'd7,  32'h2222_2222, 5'd7,  5'd7,  32'h1111_2222, 32'h1111_2222};
    vecs[6]  = '{1'b0, 4'h0, 5'd0,  32'h0,         5'd7,  5'd5,  32'h1111_2222, 32'h12BB_56DD};
    vecs[7]  = '{1'b1, 4'hF, 5'd0,  32'hCAFE_F00D, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{1'b0, 4'h0, 5'd0,  32'h0,         5'd0,  5'd1,  32'h0000_0000, 32'h0000_0002};
    vecs[9]  = '{1'b1, 4'h0, 5'd10, 32'hFFFF_FFFF, 5'd10, 5'd10, 32'h0000_000B, 32'h0000_000B};
    vecs[10] = '{1'b1, 4'h1, 5'd3,  32'h5555_55AA, 5'd3,  5'd4,  32'h0000_00AA, 32'h0000_0005};
    vecs[11] = '{1'b0, 4'h0, 5'd0,  32'h0,         5'd3,  5'd10, 32'h0000_00AA, 32'h0000_000B};
    for (int v = 0; v < 12; v++) begin
      @(negedge clock);
      regWrite  = vecs[v].we;
      writeMask = vecs[v].mask;
      regDest   = vecs[v].dest;
      writeData = vecs[v].wdata;
      readReg1  = vecs[v].r1;
      readReg2  = vecs[v].r2;
      sbq.push_back('{e1: vecs[v].exp1, e2: vecs[v].exp2});
      #2;
      e = sbq.pop_front();
      check($sformatf("vec%0d_rd1", v), readData1, e.e1);
      check($sformatf("vec%0d_rd2", v), readData2, e.e2);
      @(posedge clock);
      if (vecs[v].we) mdl_write(vecs[v].dest, vecs[v].wdata, vecs[v].mask);
      #1;
      regWrite = 1'b0;
    end

    // Clear request with a colliding write: no bypass, write dropped
    @(negedge clock);
    clearReq  = 1'b1;
    regWrite  = 1'b1;
    regDest   = 5'd9;
    writeData = 32'hDEAD_BEEF;
    writeMask = 4'hF;
    readReg1  = 5'd9;
    readReg2  = 5'd9;
    #2;
    check("clrreq_nobypass_rd1", readData1, 32'h0000_000A);
    check("clrreq_nobypass_rd2", readData2, 32'h0000_000A);
    @(posedge clock);
    #1;
    clearReq = 1'b0;
    readReg1 = 5'd31;
    check("clrreq_ready_drop", {31'b0, ready}, 32'd0);
    check("clrreq_clearing", {31'b0, clearing}, 32'd1);
    #1;
    check("clear_rd_zero", readData1, 32'h0);
    wait_ready("clrreq_edges", 32);
    regWrite = 1'b0;
    clear_model();
    for (int k = 0; k < 32; k += 2) sb_read("post_clrreq", 5'(k), 5'(k + 1));

    // Reset pulsed at clear edge 10 restarts the full sequence
    do_write(5'd20, 32'h0000_0055, 4'hF);
    sb_read("pre_midclr", 5'd20, 5'd19);
    @(negedge clock);
    clearReq = 1'b1;
    @(posedge clock);
    #1;
    clearReq = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset_   = 1'b0;
    readReg1 = 5'd20;
    #1;
    check("midclr_rst_ready", {31'b0, ready}, 32'd0);
    check("midclr_rst_clearing", {31'b0, clearing}, 32'd1);
    check("midclr_rst_rd", readData1, 32'h0);
    @(negedge clock);
    reset_ = 1'b1;
    wait_ready("midclr_reset_edges", 32);
    clear_model();
    sb_read("post_midclr", 5'd20, 5'd31);
    do_write(5'd31, 32'hA5A5_5A5A, 4'hF);
    sb_read("final", 5'd31, 5'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
